// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// memory geometry defaults and the processor word width.
package imem_loader_pkg;

  localparam int DEPTH_DEF  = 64;
  localparam int ADDR_W_DEF = 6;
  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Big-endian shift-in: earlier bytes move toward the MSB end.
  function automatic logic [WORD_W-1:0] shift_in_byte(
    input logic [WORD_W-1:0] word,
    input logic [BYTE_W-1:0] b
  );
    return {word[WORD_W-BYTE_W-1:0], b};
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Collects four bytes into one 32-bit word, first byte in [31:24].
// word_full is high in the cycle the fourth byte is being shifted in, and
// word_next already holds the completed word in that cycle.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_next,
  output logic              word_full
);

  logic [WORD_W-1:0] word_q;
  logic [1:0]        cnt_q;

  assign word_next = shift_in_byte(word_q, byte_in);
  assign word_full = shift_en && (cnt_q == 2'd3);

  // Shift register and byte count; the count wraps to 0 after the 4th byte.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift_en) begin
      word_q <= word_next;
      cnt_q  <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a byte stream, packs it into 32-bit
// words and writes them to consecutive addresses while holding the CPU in
// reset. All outputs are registered and derived from the next state so they
// line up with the state they describe.
//
// Byte handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both high; byte_data must be stable while byte_valid is
// high, and byte_ready is high only while the loader is receiving.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W:0]   num_words_q;
  logic [ADDR_W:0]   word_cnt;
  logic              count_ok;
  logic              start_ok;
  logic              start_bad;
  logic              accept;
  logic              last_word;
  logic              word_full;
  logic [WORD_W-1:0] word_next;

  assign count_ok  = (num_words != '0) && (num_words <= (ADDR_W+1)'(DEPTH));
  assign start_ok  = (state == ST_IDLE) && start && count_ok;
  assign start_bad = (state == ST_IDLE) && start && !count_ok;
  assign accept    = byte_valid && (state == ST_RECV);
  assign last_word = (word_cnt == num_words_q - (ADDR_W+1)'(1));
  assign dbg_state = state;

  byte_assembler u_asm (
    .clk       (CLK),
    .rst       (RST),
    .clr       (start_ok),
    .shift_en  (accept),
    .byte_in   (byte_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  // Next-state logic for the load sequence.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_ok) state_next = ST_RECV;
      ST_RECV:  if (word_full) state_next = ST_WRITE;
      ST_WRITE: state_next = last_word ? ST_DONE : ST_RECV;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      num_words_q <= '0;
      word_cnt    <= '0;
      byte_ready  <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      cpu_rst     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state      <= state_next;
      byte_ready <= (state_next == ST_RECV);
      imem_we    <= (state_next == ST_WRITE);
      busy       <= (state_next != ST_IDLE);
      done       <= (state_next == ST_DONE);
      err        <= start_bad;
      if (start_ok) begin
        num_words_q <= num_words;
        word_cnt    <= '0;
        cpu_rst     <= 1'b1;
      end
      // Address and data load only when a word completes, so they hold
      // their last values at every other time.
      if (word_full) begin
        imem_addr  <= word_cnt[ADDR_W-1:0];
        imem_wdata <= word_next;
      end
      if (state == ST_WRITE) word_cnt <= word_cnt + (ADDR_W+1)'(1);
      if (state == ST_DONE) cpu_rst <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized byte streams against a reference
// model built from the loader's transaction rules.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int AW_W   = ADDR_W + 32;

  logic              CLK;
  logic              RST;
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        dbg_state;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Expected control outputs for the current cycle.
  logic e_ready, e_we, e_busy, e_done, e_err, e_cpu;
  logic n_ready, n_we, n_busy, n_done, n_err, n_cpu;
  logic acc, bad, hs, fourth, last_wr;
  logic [AW_W-1:0] exp_q[$];
  logic [AW_W-1:0] last_aw;
  logic [AW_W-1:0] exp_w;
  logic [7:0]      cur_bytes [4];
  int nb, m_n, wformed, wwritten;
  bit mon_on = 1'b0;

  int err_seen = 0;
  int wr_seen  = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [31:0]       mem_seen [DEPTH];

  // Outputs compared at the falling edge, then the model steps using the
  // inputs the next rising edge will sample.
  always @(negedge CLK) begin
    if (mon_on) begin
      chk("ctl{ready,we,busy,done,err,cpu_rst}",
          {byte_ready, imem_we, busy, done, err, cpu_rst},
          {e_ready, e_we, e_busy, e_done, e_err, e_cpu});
      if (imem_we) begin
        wr_seen++;
        last_wr_addr = imem_addr;
        mem_seen[imem_addr] = imem_wdata;
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          exp_w = exp_q.pop_front();
          chk("write{addr,data}", {imem_addr, imem_wdata}, exp_w);
          last_aw = exp_w;
        end
      end else begin
        chk("hold{addr,data}", {imem_addr, imem_wdata}, last_aw);
      end
      if (err) err_seen++;
    end

    if (RST) begin
      e_ready = 0; e_we = 0; e_busy = 0; e_done = 0; e_err = 0; e_cpu = 1;
      exp_q.delete();
      last_aw = '0;
      nb = 0; m_n = 0; wformed = 0; wwritten = 0;
      mon_on = 1'b1;
    end else if (mon_on) begin
      acc     = start && !e_busy && (num_words >= 1) && (num_words <= DEPTH);
      bad     = start && !e_busy && ((num_words == 0) || (num_words > DEPTH));
      hs      = byte_valid && e_ready;
      fourth  = hs && (nb == 3);
      last_wr = e_we && (wwritten + 1 == m_n);

      n_we    = fourth;
      n_done  = last_wr;
      n_ready = acc || (e_ready && !fourth) || (e_we && !last_wr);
      n_busy  = acc || (e_busy && !e_done);
      n_cpu   = acc ? 1'b1 : (e_done ? 1'b0 : e_cpu);
      n_err   = bad;

      if (e_we) wwritten++;
      if (hs) begin
        cur_bytes[nb] = byte_data;
        if (nb == 3) begin
          exp_q.push_back({ADDR_W'(wformed),
                           cur_bytes[0], cur_bytes[1], cur_bytes[2], cur_bytes[3]});
          wformed++;
          nb = 0;
        end else nb++;
      end
      if (acc) begin
        m_n = num_words; wformed = 0; wwritten = 0; nb = 0;
      end

      e_ready = n_ready; e_we = n_we; e_busy = n_busy;
      e_done = n_done; e_err = n_err; e_cpu = n_cpu;
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] byte_src[$];

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) byte_src.push_back(8'($urandom_range(0, 255)));
  endtask

  // Called at posedge+1 with the loader idle; returns at posedge+1.
  task automatic do_start(input int n);
    start = 1'b1;
    num_words = (ADDR_W+1)'(n);
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // mode 0: valid held high, 1: valid toggles 1,0,1,0, 2: random valid.
  task automatic send_bytes(input int nbytes, input int mode, input bit poke);
    int sent = 0;
    int cyc = 0;
    bit tog = 1'b1;
    while (sent < nbytes && cyc < 4000) begin
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = tog;
        default: byte_valid = ($urandom_range(0, 2) != 0);
      endcase
      tog = !tog;
      byte_data = byte_valid ? byte_src[0] : 8'($urandom_range(0, 255));
      if (poke) begin
        start = ($urandom_range(0, 3) == 0);
        num_words = (ADDR_W+1)'($urandom_range(0, 127));
      end
      @(negedge CLK);
      if (byte_valid && byte_ready) begin
        sent++;
        void'(byte_src.pop_front());
      end
      @(posedge CLK); #1;
      cyc++;
    end
    byte_valid = 1'b0;
    start = 1'b0;
    chk("bytes_sent", sent, nbytes);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    @(posedge CLK); #1;
  endtask

  task automatic run_load(input int n, input int mode, input bit poke);
    fill_random(4 * n);
    do_start(n);
    send_bytes(4 * n, mode, poke);
    wait_done();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int errs0, wr0, n;
    logic [7:0]  b[4];
    logic [31:0] w_exp;

    for (int i = 0; i < DEPTH; i++) mem_seen[i] = '0;
    RST = 1'b1; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;

    // Reset values.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outputs",
        {cpu_rst, busy, done, err, byte_ready, imem_we, imem_addr, imem_wdata},
        {1'b1, 5'b0, {ADDR_W{1'b0}}, 32'h0});
    chk("reset_state", dbg_state, 0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Basic load, valid held high.
    foreach (byte_src[i]) ;
    byte_src = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h00};
    do_start(2);
    send_bytes(8, 0, 1'b0);
    wait_done();
    chk("basic_word0", mem_seen[0], 32'h20080005);
    chk("basic_word1", mem_seen[1], 32'h8C010000);
    @(negedge CLK);
    chk("basic_cpu_rst_low", cpu_rst, 0);
    @(posedge CLK); #1;

    // Same stream with back-pressure.
    mem_seen[0] = '0; mem_seen[1] = '0;
    byte_src = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h00};
    do_start(2);
    send_bytes(8, 1, 1'b0);
    wait_done();
    chk("bp_word0", mem_seen[0], 32'h20080005);
    chk("bp_word1", mem_seen[1], 32'h8C010000);

    // Rejected counts: 0, DEPTH+1 and the largest encodable count.
    foreach (b[i]) b[i] = '0;
    wr0 = wr_seen;
    errs0 = err_seen;
    do_start(0);
    repeat (3) @(posedge CLK); #1;
    chk("err_pulse_zero", err_seen - errs0, 1);
    errs0 = err_seen;
    do_start(DEPTH + 1);
    repeat (3) @(posedge CLK); #1;
    chk("err_pulse_65", err_seen - errs0, 1);
    errs0 = err_seen;
    do_start(127);
    repeat (3) @(posedge CLK); #1;
    chk("err_pulse_127", err_seen - errs0, 1);
    chk("bad_count_no_write", wr_seen - wr0, 0);

    // Mid-load reset after 6 bytes of a 4-word load.
    fill_random(6);
    do_start(4);
    send_bytes(6, 2, 1'b0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_state", dbg_state, 0);
    chk("midrst_cpu_rst", cpu_rst, 1);
    @(posedge CLK); #1;
    mem_seen[0] = '0;
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom_range(0, 255));
      byte_src.push_back(b[i]);
    end
    w_exp = {b[0], b[1], b[2], b[3]};
    wr0 = wr_seen;
    do_start(1);
    send_bytes(4, 2, 1'b0);
    wait_done();
    chk("post_rst_addr", last_wr_addr, 0);
    chk("post_rst_word", mem_seen[0], w_exp);
    chk("post_rst_writes", wr_seen - wr0, 1);

    // Full depth with start pulses while busy.
    wr0 = wr_seen;
    run_load(DEPTH, 2, 1'b1);
    chk("full_last_addr", last_wr_addr, DEPTH - 1);
    chk("full_write_count", wr_seen - wr0, DEPTH);

    // Random short loads.
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(1, 8);
      run_load(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge CLK);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
